// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic result collector: data width and collector FSM states.
package systolic_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrain  = 2'd1,
        StFlush  = 2'd2,
        StStream = 2'd3
    } collector_state_e;

endpackage

// File: rtl/result_buffer.sv
// Result storage: one synchronous write port and one combinational read port.
module result_buffer
    import systolic_pkg::*;
#(
    parameter int unsigned Depth = 64
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(Depth)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/systolic_result_collector.sv
// Drains a PE chain serially into a buffer, then streams the words out with valid/ready.
module systolic_result_collector
    import systolic_pkg::*;
#(
    parameter int unsigned PE_NUMBER    = 64,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         read,
    input  logic [DATA_W-1:0]            l_d_o,
    output logic [DATA_W-1:0]            res_data,
    output logic [$clog2(PE_NUMBER)-1:0] res_idx,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned IdxW = $clog2(PE_NUMBER);
    localparam int unsigned PtrW = IdxW + 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(PE_NUMBER - 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(PE_NUMBER - 1);

    collector_state_e        state_q, state_d;
    logic [IdxW-1:0]         drain_cnt_q, drain_cnt_d;
    logic [IdxW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [READ_LATENCY-1:0] rd_dly_q, rd_dly_d;
    logic                    done_q, done_d;
    logic                    wr_en, last_wr, accept;
    logic [DATA_W-1:0]       buf_rdata;

    assign read      = (state_q == StDrain);
    assign res_valid = (state_q == StStream);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign accept    = res_valid && res_ready;

    // A word arrives READ_LATENCY cycles after its read strobe.
    assign wr_en   = rd_dly_q[READ_LATENCY-1];
    assign last_wr = wr_en && (wr_ptr_q == LastPtr);

    assign res_data = res_valid ? buf_rdata : '0;
    assign res_idx  = res_valid ? rd_ptr_q : '0;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        done_d      = 1'b0;
        rd_dly_d[0] = read;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            rd_dly_d[i] = rd_dly_q[i-1];
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                // The done cycle itself swallows start.
                if (start && !done_q) begin
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                    rd_ptr_d    = '0;
                    wr_ptr_d    = '0;
                end
            end
            StDrain: begin
                if (drain_cnt_q == LastIdx) begin
                    state_d = StFlush;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            StFlush: begin
                if (last_wr) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                if (accept) begin
                    if (rd_ptr_q == LastIdx) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            drain_cnt_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_dly_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_dly_q    <= rd_dly_d;
            done_q      <= done_d;
        end
    end

    result_buffer #(
        .Depth(PE_NUMBER)
    ) u_result_buffer (
        .clk_i  (clk),
        .we_i   (wr_en),
        .waddr_i(wr_ptr_q[IdxW-1:0]),
        .wdata_i(l_d_o),
        .raddr_i(rd_ptr_q),
        .rdata_o(buf_rdata)
    );

endmodule

// File: doc/systolic_result_collector.md
SYSTOLIC_RESULT_COLLECTOR -- requirements
Module: systolic_result_collector

Interface
REQ-001 SHALL have parameter PE_NUMBER, default 64, number of PEs in the drained chain (>= 2).
REQ-002 SHALL have parameter READ_LATENCY, default 1, cycles from read=1 to the first valid word on l_d_o (1..4).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to drain the array; sampled only in IDLE.
REQ-006 SHALL have port read, output, 1, shift-out enable to the array.
REQ-007 SHALL have port l_d_o, input, 16, serial result word from the array.
REQ-008 SHALL have port res_data, output, 16, buffered result word.
REQ-009 SHALL have port res_idx, output, $clog2(PE_NUMBER), PE index of res_data (0 = PE nearest the output).
REQ-010 SHALL have port res_valid, output, 1, res_data/res_idx valid.
REQ-011 SHALL have port res_ready, input, 1, downstream accepts the word.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse after the last word is accepted.

Function
REQ-014 SHALL implement the FSM states IDLE, DRAIN, FLUSH and STREAM.
REQ-015 IDLE->DRAIN SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-016 In DRAIN, read SHALL be 1 for exactly PE_NUMBER consecutive cycles, counted by drain_cnt 0..PE_NUMBER-1; on the last count the FSM SHALL go to FLUSH.
REQ-017 Capture SHALL occur READ_LATENCY cycles after each read=1 cycle: l_d_o is written to buffer[k] for the k-th read cycle (k = 0..PE_NUMBER-1), using a READ_LATENCY-deep delayed copy of read and a write pointer.
REQ-018 FLUSH SHALL hold read=0 for READ_LATENCY cycles until the write pointer reaches PE_NUMBER, then go to STREAM.
REQ-019 STREAM SHALL hold res_valid=1 with res_data=buffer[rd_ptr] and res_idx=rd_ptr; rd_ptr SHALL advance only when res_valid && res_ready.
REQ-020 res_data and res_idx SHALL remain stable while res_valid=1 and res_ready=0.
REQ-021 Acceptance at rd_ptr=PE_NUMBER-1 SHALL return the FSM to IDLE, clear res_valid in the next cycle, and pulse done=1 for one cycle in that cycle.
REQ-022 A start asserted in the same cycle as done SHALL be ignored; a new drain needs start while IDLE with done=0.
REQ-023 Data SHALL pass through unmodified (no arithmetic); pointers SHALL not wrap within a transaction and SHALL clear to 0 on entry to DRAIN.
REQ-024 res_ready SHALL be ignored outside STREAM.

Reset
REQ-025 Reset SHALL force state=IDLE, read=0, res_valid=0, done=0, busy=0, res_idx=0, res_data=0, and all counters, pointers and read-delay stages to 0.
REQ-026 Reset mid-DRAIN/FLUSH/STREAM SHALL abort the transaction, drop read the next cycle, and not pulse done; buffer contents are don't-care after reset.

Structure
REQ-027 A shared package systolic_pkg SHALL hold DATA_W=16 and the collector state enum; PE_NUMBER remains a module parameter.
REQ-028 The PE_NUMBER x 16 storage SHALL be a sub-module result_buffer (one synchronous write port, one combinational read port).

Verification
REQ-029 PE_NUMBER=4, READ_LATENCY=1, array model drives 0x0011, 0x0022, 0x0033, 0x0044, start pulse, res_ready=1 -> read high for exactly 4 cycles, stream idx 0..3 = 0x0011..0x0044, done pulses once, busy low after.
REQ-030 Same setup, res_ready toggling 1,0,0,1,... -> no word lost or duplicated, and res_data is held while stalled.
REQ-031 READ_LATENCY=3, words 0xA000+k -> buffer[k]=0xA000+k and FLUSH lasts 3 cycles.
REQ-032 start held high through the whole transaction -> exactly one drain per IDLE entry, no read during STREAM.
REQ-033 reset asserted on the 2nd DRAIN cycle -> read=0, res_valid=0 next cycle, no done; a following start completes normally.
REQ-034 PE_NUMBER=64 default with ramp data 0..63 -> 64 words in order, res_idx reaching 63, then done.
